// File: rtl/floating_multiplication_if.sv
// Operand/result bundle for the binary32 multiplier.
// master drives operands, slave returns registered results.
interface floating_multiplication_if;
  logic        EN;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] OUT_MUL;
  logic        zero;
  logic        infinity;
  logic        Flag_Mul;

  modport master (
    output EN,
    output A,
    output B,
    input  OUT_MUL,
    input  zero,
    input  infinity,
    input  Flag_Mul
  );

  modport slave (
    input  EN,
    input  A,
    input  B,
    output OUT_MUL,
    output zero,
    output infinity,
    output Flag_Mul
  );
endinterface

// File: rtl/floating_multiplication.sv
// IEEE-754 binary32 multiplier, flush-to-zero, RNE rounding.
// Combinational datapath with a single output register stage.
module floating_multiplication (
  input logic                       CLK,
  input logic                       RST,
  floating_multiplication_if.slave  bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        w_sa;
  logic        w_sb;
  logic        w_sign;
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [22:0] w_fa;
  logic [22:0] w_fb;

  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_invalid;
  logic        w_any_inf;
  logic        w_any_zero;

  logic [23:0] w_ma;
  logic [23:0] w_mb;
  logic [47:0] w_prod;
  logic        w_hi;
  logic [22:0] w_frac;
  logic        w_guard;
  logic        w_sticky;
  logic        w_rup;
  logic [23:0] w_rnd;
  logic [22:0] w_frac_fin;

  logic signed [10:0] w_exp_raw;
  logic signed [10:0] w_exp_fin;
  logic        w_ovf;
  logic        w_unf;

  logic [31:0] w_out;
  logic        w_zero;
  logic        w_inf;

  logic [31:0] r_out;
  logic        r_zero;
  logic        r_inf;
  logic        r_flag;

  assign w_sa = bus.A[31];
  assign w_sb = bus.B[31];
  assign w_ea = bus.A[30:23];
  assign w_eb = bus.B[30:23];
  assign w_fa = bus.A[22:0];
  assign w_fb = bus.B[22:0];

  assign w_sign = w_sa ^ w_sb;

  // exponent 0 covers subnormals too: they flush to zero
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'h0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'h0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'h0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'h0);

  assign w_invalid = w_a_nan || w_b_nan ||
                     (w_a_inf && w_b_zero) ||
                     (w_b_inf && w_a_zero);
  assign w_any_inf  = w_a_inf || w_b_inf;
  assign w_any_zero = w_a_zero || w_b_zero;

  assign w_ma   = {1'b1, w_fa};
  assign w_mb   = {1'b1, w_fb};
  assign w_prod = 48'(w_ma) * 48'(w_mb);

  // product is in [1,4): at most one right shift
  assign w_hi = w_prod[47];

  always_comb begin
    w_frac   = w_prod[45:23];
    w_guard  = w_prod[22];
    w_sticky = |w_prod[21:0];
    if (w_hi) begin
      w_frac   = w_prod[46:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
    end
  end

  assign w_rup = w_guard & (w_sticky | w_frac[0]);
  assign w_rnd = {1'b0, w_frac} + 24'(w_rup);

  // carry out of rounding means significand became exactly 2.0
  assign w_frac_fin = w_rnd[23] ? 23'h0 : w_rnd[22:0];

  assign w_exp_raw = $signed({3'b000, w_ea}) +
                     $signed({3'b000, w_eb}) -
                     11'sd127;

  assign w_exp_fin = w_exp_raw +
                     $signed({10'd0, w_hi}) +
                     $signed({10'd0, w_rnd[23]});

  assign w_ovf = (w_exp_fin >= 11'sd255);
  assign w_unf = (w_exp_fin <= 11'sd0);

  always_comb begin
    w_out  = {w_sign, w_exp_fin[7:0], w_frac_fin};
    w_zero = 1'b0;
    w_inf  = 1'b0;
    if (w_invalid) begin
      w_out = QNAN;
    end else if (w_any_inf) begin
      w_out = {w_sign, 8'hFF, 23'h0};
      w_inf = 1'b1;
    end else if (w_any_zero) begin
      w_out  = {w_sign, 31'h0};
      w_zero = 1'b1;
    end else if (w_ovf) begin
      w_out = {w_sign, 8'hFF, 23'h0};
      w_inf = 1'b1;
    end else if (w_unf) begin
      w_out  = {w_sign, 31'h0};
      w_zero = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out  <= 32'h0;
      r_zero <= 1'b0;
      r_inf  <= 1'b0;
      r_flag <= 1'b0;
    end else if (bus.EN) begin
      r_out  <= w_out;
      r_zero <= w_zero;
      r_inf  <= w_inf;
      r_flag <= 1'b1;
    end else begin
      r_flag <= 1'b0;
    end
  end

  assign bus.OUT_MUL  = r_out;
  assign bus.zero     = r_zero;
  assign bus.infinity = r_inf;
  assign bus.Flag_Mul = r_flag;

endmodule

// File: tb/tb_floating_multiplication.sv
// Bench for the binary32 multiplier: directed vectors,
// random operands against an exact-integer RNE model.
module tb_floating_multiplication;

  logic CLK;
  logic RST;

  floating_multiplication_if ifc ();

  floating_multiplication dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // returns {product, zero, infinity}
  function automatic logic [33:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    logic s;
    int ea, eb, e, n, sh;
    longint unsigned fa, fb, p, q, rem, half;
    bit an, ai, az, bn, bi, bz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = {41'd0, a[22:0]};
    fb = {41'd0, b[22:0]};
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (fa == 0);
    bi = (eb == 255) && (fb == 0);
    an = (ea == 255) && (fa != 0);
    bn = (eb == 255) && (fb != 0);
    if (an || bn || (ai && bz) || (bi && az))
      return {32'h7FC00000, 2'b00};
    if (ai || bi)
      return {s, 8'hFF, 23'h0, 2'b01};
    if (az || bz)
      return {s, 31'h0, 2'b10};
    p = (fa | 64'h800000) * (fb | 64'h800000);
    n = 0;
    for (int k = 0; k < 64; k++)
      if (p[k]) n = k;
    sh   = n - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0]))
      q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      n++;
    end
    e = ea + eb - 127 + (n - 46);
    if (e >= 255)
      return {s, 8'hFF, 23'h0, 2'b01};
    if (e <= 0)
      return {s, 31'h0, 2'b10};
    return {s, 8'(e), q[22:0], 2'b00};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: v[30:23] = 8'h00;
      1: begin
        v[30:23] = 8'hFF;
        v[22:0]  = 23'h0;
      end
      2: v[30:23] = 8'hFF;
      3: v[30:23] = 8'($urandom_range(235, 254));
      4: v[30:23] = 8'($urandom_range(1, 25));
      5, 6, 7, 8, 9:
        v[30:23] = 8'($urandom_range(100, 154));
      default:
        v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  task automatic fire(input logic [31:0] a, input logic [31:0] b);
    ifc.EN = 1'b1;
    ifc.A  = a;
    ifc.B  = b;
    @(posedge CLK);
    #1;
    ifc.EN = 1'b0;
  endtask

  task automatic run_ref(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] b);
    logic [33:0] r;
    r = ref_mul(a, b);
    fire(a, b);
    chk({tag, ".out"}, ifc.OUT_MUL, r[33:2]);
    chk({tag, ".zero"}, 32'(ifc.zero), 32'(r[1]));
    chk({tag, ".inf"}, 32'(ifc.infinity), 32'(r[0]));
    chk({tag, ".flag"}, 32'(ifc.Flag_Mul), 32'd1);
    chk({tag, ".excl"}, 32'(ifc.zero & ifc.infinity), 32'd0);
  endtask

  task automatic run_lit(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eo,
                         input logic ez,
                         input logic ei);
    fire(a, b);
    chk({tag, ".out"}, ifc.OUT_MUL, eo);
    chk({tag, ".zero"}, 32'(ifc.zero), 32'(ez));
    chk({tag, ".inf"}, 32'(ifc.infinity), 32'(ei));
    chk({tag, ".flag"}, 32'(ifc.Flag_Mul), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out"}, ifc.OUT_MUL, 32'h0);
    chk({tag, ".zero"}, 32'(ifc.zero), 32'd0);
    chk({tag, ".inf"}, 32'(ifc.infinity), 32'd0);
    chk({tag, ".flag"}, 32'(ifc.Flag_Mul), 32'd0);
  endtask

  logic [31:0] held_out;
  logic        held_z;
  logic        held_i;

  initial begin
    RST    = 1'b0;
    ifc.EN = 1'b1;
    ifc.A  = 32'h40000000;
    ifc.B  = 32'h40000000;
    #22;
    chk_all_zero("reset");
    @(negedge CLK);
    ifc.EN = 1'b0;
    RST    = 1'b1;
    @(posedge CLK);
    #1;
    chk_all_zero("idle_after_reset");

    run_lit("inf_x_3p2", 32'h7F800000, 32'h404CCCCC,
            32'h7F800000, 1'b0, 1'b1);
    run_lit("22p3_x_m0p5", 32'h41B26666, 32'hBF000000,
            32'hC1326666, 1'b0, 1'b0);
    run_lit("minf_x_m3p2", 32'hFF800000, 32'hC04CCCCC,
            32'h7F800000, 1'b0, 1'b1);
    run_lit("zero_x_3p2", 32'h00000000, 32'h404CCCCC,
            32'h00000000, 1'b1, 1'b0);
    run_lit("inf_x_zero", 32'h7F800000, 32'h00000000,
            32'h7FC00000, 1'b0, 1'b0);
    run_lit("m6p4_x_m0p5", 32'hC0CCCCCC, 32'hBF000000,
            32'h404CCCCC, 1'b0, 1'b0);
    run_lit("6p4_x_m0p5", 32'h40CCCCCC, 32'hBF000000,
            32'hC04CCCCC, 1'b0, 1'b0);
    run_ref("15p8_x_1p3", 32'h417CCCCD, 32'h3FA66666);
    run_lit("tie_up", 32'h3FC00000, 32'h3F800001,
            32'h3FC00002, 1'b0, 1'b0);
    run_lit("tie_even", 32'h3FC00000, 32'h3F800003,
            32'h3FC00004, 1'b0, 1'b0);
    run_lit("ovf", 32'h7F000000, 32'h40000000,
            32'h7F800000, 1'b0, 1'b1);
    run_lit("ovf_neg", 32'hFF000000, 32'h40000000,
            32'hFF800000, 1'b0, 1'b1);
    run_lit("unf", 32'h00800000, 32'h3F000000,
            32'h00000000, 1'b1, 1'b0);
    run_lit("min_norm", 32'h00800000, 32'h3F800000,
            32'h00800000, 1'b0, 1'b0);
    run_lit("sub_ftz", 32'h80000001, 32'h3F800000,
            32'h80000000, 1'b1, 1'b0);
    run_lit("nan_in", 32'h7F800001, 32'h3F800000,
            32'h7FC00000, 1'b0, 1'b0);
    run_lit("ninf_x_inf", 32'hFF800000, 32'h7F800000,
            32'hFF800000, 1'b0, 1'b1);
    run_ref("carry_sq", 32'h3FFFFFFF, 32'h3FFFFFFF);
    run_ref("carry_mix", 32'h3FFFFFFF, 32'h3F800001);

    // back-to-back enables keep Flag_Mul high
    for (int i = 0; i < 300; i++)
      run_ref("rand", rnd_op(), rnd_op());

    held_out = ifc.OUT_MUL;
    held_z   = ifc.zero;
    held_i   = ifc.infinity;
    for (int i = 0; i < 3; i++) begin
      ifc.EN = 1'b0;
      ifc.A  = $urandom;
      ifc.B  = $urandom;
      @(posedge CLK);
      #1;
      chk("hold.out", ifc.OUT_MUL, held_out);
      chk("hold.zero", 32'(ifc.zero), 32'(held_z));
      chk("hold.inf", 32'(ifc.infinity), 32'(held_i));
      chk("hold.flag", 32'(ifc.Flag_Mul), 32'd0);
    end

    run_lit("pre_rst", 32'h40400000, 32'h40000000,
            32'h40C00000, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    chk_all_zero("async_rst");
    ifc.EN = 1'b1;
    ifc.A  = 32'h41200000;
    ifc.B  = 32'h41200000;
    @(posedge CLK);
    #1;
    chk_all_zero("rst_held");
    RST    = 1'b1;
    ifc.EN = 1'b0;
    @(posedge CLK);
    #1;
    chk_all_zero("pending_discard");
    run_lit("first_after_rst", 32'h41200000, 32'h41200000,
            32'h42C80000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
